// File: rtl/simon_seq_if.sv
// Bundle of the game-facing signals of the Simon sequence controller.
// The master modport drives stimulus (LFSR colour, start, timebase, buttons); the slave modport is the controller.
interface simon_seq_if;
   logic [1:0] rnd;
   logic       rnd_valid;
   logic       start;
   logic       tick;
   logic [3:0] btn;
   logic [3:0] led;
   logic [4:0] level;
   logic       busy;
   logic       game_over;
   logic       win;

   modport master (
      output rnd, rnd_valid, start, tick, btn,
      input  led, level, busy, game_over, win
   );

   modport slave (
      input  rnd, rnd_valid, start, tick, btn,
      output led, level, busy, game_over, win
   );
endinterface

// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: grows a colour sequence, plays it back on the LEDs, then checks the player's presses.
// Optional macro SIMON_TIMEOUT_EN adds a per-press tick timeout in WAIT_IN that ends the game.
//
// state      | meaning
// IDLE       | no game yet; start launches one
// EXTEND     | waiting for a colour from the LFSR to append
// SHOW_ON    | LED for mem[idx] lit for SHOW_TICKS ticks
// SHOW_OFF   | dark gap of one tick between colours
// WAIT_IN    | player repeating the sequence, idx = next expected colour
// LOSE       | wrong press (or timeout); level still shows len
// WIN        | MAX_LEN sequence completed
module simon_seq_ctrl #(
   parameter int MAX_LEN       = 16,
   parameter int SHOW_TICKS    = 4,
   parameter int TIMEOUT_TICKS = 32
) (
   input logic        clk,
   input logic        reset,
   simon_seq_if.slave bus
);

   localparam int AW      = $clog2(MAX_LEN);
   localparam int CNT_MAX = (SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXTEND,
      ST_SHOW_ON,
      ST_SHOW_OFF,
      ST_WAIT_IN,
      ST_LOSE,
      ST_WIN
   } state_t;

   state_t           r_state;
   logic [4:0]       r_len;
   logic [4:0]       r_idx;
   logic [CNT_W-1:0] r_tick_cnt;
   logic [3:0]       r_btn_prev;
   logic [3:0]       r_led;
   logic [4:0]       r_level;
   logic             r_busy;
   logic             r_game_over;
   logic             r_win;
   logic [1:0]       r_mem [MAX_LEN];

   logic [4:0]       w_len_inc;
   logic [4:0]       w_len_dec;
   logic [4:0]       w_idx_inc;
   logic             w_press;
   logic [3:0]       w_expect;
   logic [CNT_W-1:0] w_wait_load;

   function automatic logic [3:0] f_onehot(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   assign w_len_inc = r_len + 5'd1;
   assign w_len_dec = r_len - 5'd1;
   assign w_idx_inc = r_idx + 5'd1;
   assign w_press   = (bus.btn != 4'b0000) && (r_btn_prev == 4'b0000);
   assign w_expect  = f_onehot(r_mem[r_idx[AW-1:0]]);

`ifdef SIMON_TIMEOUT_EN
   assign w_wait_load = CNT_W'(TIMEOUT_TICKS);
`else
   assign w_wait_load = '0;
`endif

   // Buffer is deliberately not reset; only entries below len are ever read.
   always_ff @(posedge clk) begin
      if ((r_state == ST_EXTEND) && bus.rnd_valid)
         r_mem[r_len[AW-1:0]] <= bus.rnd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_len       <= '0;
         r_idx       <= '0;
         r_tick_cnt  <= '0;
         r_btn_prev  <= 4'b1111;
         r_led       <= '0;
         r_level     <= '0;
         r_busy      <= 1'b0;
         r_game_over <= 1'b0;
         r_win       <= 1'b0;
      end else begin
         r_btn_prev <= bus.btn;
         // Tick counter is a down-counter; each entry reloads it, so a tick on the entry cycle is not counted.
         if (bus.tick && (r_tick_cnt != '0))
            r_tick_cnt <= r_tick_cnt - CNT_W'(1);

         unique case (r_state)
            ST_IDLE, ST_LOSE, ST_WIN: begin
               if (bus.start) begin
                  r_state     <= ST_EXTEND;
                  r_len       <= '0;
                  r_idx       <= '0;
                  r_tick_cnt  <= '0;
                  r_level     <= '0;
                  r_led       <= '0;
                  r_busy      <= 1'b1;
                  r_game_over <= 1'b0;
                  r_win       <= 1'b0;
               end
            end
            ST_EXTEND: begin
               if (bus.rnd_valid) begin
                  r_state    <= ST_SHOW_ON;
                  r_len      <= w_len_inc;
                  r_level    <= w_len_inc;
                  r_idx      <= '0;
                  r_tick_cnt <= CNT_W'(SHOW_TICKS);
                  // On the first round mem[0] is being written this very cycle.
                  r_led      <= (r_len == 5'd0) ? f_onehot(bus.rnd) : f_onehot(r_mem[0]);
               end
            end
            ST_SHOW_ON: begin
               if (bus.tick && (r_tick_cnt == CNT_W'(1))) begin
                  r_state    <= ST_SHOW_OFF;
                  r_tick_cnt <= '0;
                  r_led      <= '0;
               end
            end
            ST_SHOW_OFF: begin
               if (bus.tick) begin
                  if (r_idx == w_len_dec) begin
                     r_state    <= ST_WAIT_IN;
                     r_idx      <= '0;
                     r_tick_cnt <= w_wait_load;
                  end else begin
                     r_state    <= ST_SHOW_ON;
                     r_idx      <= w_idx_inc;
                     r_tick_cnt <= CNT_W'(SHOW_TICKS);
                     r_led      <= f_onehot(r_mem[w_idx_inc[AW-1:0]]);
                  end
               end
            end
            ST_WAIT_IN: begin
               if (w_press) begin
                  if (bus.btn != w_expect) begin
                     r_state     <= ST_LOSE;
                     r_busy      <= 1'b0;
                     r_game_over <= 1'b1;
                  end else if (r_idx != w_len_dec) begin
                     r_idx      <= w_idx_inc;
                     r_tick_cnt <= w_wait_load;
                  end else if (r_len == 5'(MAX_LEN)) begin
                     r_state <= ST_WIN;
                     r_busy  <= 1'b0;
                     r_win   <= 1'b1;
                  end else begin
                     r_state    <= ST_EXTEND;
                     r_tick_cnt <= '0;
                  end
               end
`ifdef SIMON_TIMEOUT_EN
               else if (bus.tick && (r_tick_cnt == CNT_W'(1))) begin
                  r_state     <= ST_LOSE;
                  r_busy      <= 1'b0;
                  r_game_over <= 1'b1;
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.led       = r_led;
   assign bus.level     = r_level;
   assign bus.busy      = r_busy;
   assign bus.game_over = r_game_over;
   assign bus.win       = r_win;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Scoreboard bench for simon_seq_ctrl: a game-level model queues expected displays and endings,
// an independent monitor pops and compares them as the LEDs and status flags change.
module tb_simon_seq_ctrl;
   localparam int MAX_LEN       = 3;
   localparam int SHOW_TICKS    = 4;
   localparam int TIMEOUT_TICKS = 32;
   localparam int EV_SHOW = 0;
   localparam int EV_LOSE = 1;
   localparam int EV_WIN  = 2;

   typedef struct {
      int kind;
      int colour;
      int level;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   simon_seq_if bus();

   simon_seq_ctrl #(
      .MAX_LEN      (MAX_LEN),
      .SHOW_TICKS   (SHOW_TICKS),
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   ev_t  sb[$];
   int   seq[$];
   int   shows_seen = 0;
   int   ends_seen  = 0;

   function automatic void chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push_ev(int kind, int colour, int level);
      ev_t e;
      e.kind = kind; e.colour = colour; e.level = level;
      sb.push_back(e);
   endfunction

   // Timebase: random one-cycle strobes, roughly one in three cycles.
   initial begin
      bus.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tick = ($urandom_range(0, 2) == 0);
      end
   end

   // Monitor
   bit         m_in_show = 0;
   int         m_led, m_level, m_busy, m_dur;
   bit         m_prev_go = 0, m_prev_win = 0;
   logic [3:0] m_prev_led = '0;

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         m_in_show  = 0;
         m_prev_go  = 0;
         m_prev_win = 0;
         m_prev_led = '0;
      end else begin
         if (!m_in_show && bus.led != 4'b0 && m_prev_led == 4'b0) begin
            m_in_show = 1;
            m_led     = int'(bus.led);
            m_level   = int'(bus.level);
            m_busy    = int'(bus.busy);
            m_dur     = 0;
         end
         if (m_in_show && bus.led != 4'b0) begin
            if (int'(bus.led) != m_led) chk("led_stable", int'(bus.led), m_led);
            if (bus.tick) m_dur++;
         end else if (m_in_show) begin
            m_in_show = 0;
            shows_seen++;
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_show: led %0d with nothing expected", m_led);
            end else begin
               e = sb.pop_front();
               chk("show_kind", EV_SHOW, e.kind);
               chk("show_led", m_led, 1 << e.colour);
               chk("show_level", m_level, e.level);
               chk("show_ticks", m_dur, SHOW_TICKS);
               chk("show_busy", m_busy, 1);
            end
         end
         if ((bus.game_over && !m_prev_go) || (bus.win && !m_prev_win)) begin
            ends_seen++;
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_end: game_over %0d win %0d", bus.game_over, bus.win);
            end else begin
               e = sb.pop_front();
               chk("end_kind", bus.win ? EV_WIN : EV_LOSE, e.kind);
               chk("end_level", int'(bus.level), e.level);
               chk("end_busy", int'(bus.busy), 0);
               chk("end_led", int'(bus.led), 0);
            end
         end
         m_prev_go  = bus.game_over;
         m_prev_win = bus.win;
         m_prev_led = bus.led;
      end
   end

   // Driver / model
   task automatic abort(string why);
      tests++; fails++;
      $display("FAIL %s: wait bound expired", why);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ticks(int n);
      int c = 0;
      int guard = 0;
      while (c < n) begin
         @(negedge clk);
         if (bus.tick) c++;
         guard++;
         if (guard > n * 50 + 100) abort("wait_ticks");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      seq.delete();
   endtask

   // Append colour c, expect the whole sequence replayed, and return once the player may press.
   task automatic extend_and_show(int c);
      int target;
      int guard = 0;
      cyc($urandom_range(0, 3));
      seq.push_back(c);
      foreach (seq[i]) push_ev(EV_SHOW, seq[i], seq.size());
      target = shows_seen + seq.size();
      bus.rnd = 2'(c);
      bus.rnd_valid = 1'b1;
      cyc(1);
      bus.rnd_valid = 1'b0;
      while (shows_seen < target) begin
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.rnd_valid = ($urandom_range(0, 2) == 0);
         bus.rnd       = 2'($urandom_range(0, 3));
         cyc(1);
         guard++;
         if (guard > 200 * seq.size() + 200) abort("playback");
      end
      bus.start     = 1'b0;
      bus.rnd_valid = 1'b0;
      wait_ticks(2);
   endtask

   task automatic press(int v);
      bus.btn = 4'(v);
      cyc($urandom_range(1, 10));
      bus.btn = 4'b0;
      cyc($urandom_range(1, 3));
   endtask

   task automatic wait_end(int target);
      int guard = 0;
      while (ends_seen < target) begin
         cyc(1);
         guard++;
         if (guard > 3000) abort("game_end");
      end
   endtask

   task automatic wrong_press(int idx);
      int v;
      int target;
      do v = $urandom_range(1, 15); while (v == (1 << seq[idx]));
      push_ev(EV_LOSE, 0, seq.size());
      target = ends_seen + 1;
      press(v);
      wait_end(target);
   endtask

   task automatic run_random_game(int err_pct);
      bit done = 0;
      int target;
      start_game();
      while (!done) begin
         extend_and_show($urandom_range(0, 3));
         if ($urandom_range(0, 99) < err_pct) begin
            int bad = $urandom_range(0, seq.size() - 1);
            for (int i = 0; i < bad; i++) press(1 << seq[i]);
            wrong_press(bad);
            done = 1;
         end else begin
            for (int i = 0; i < seq.size() - 1; i++) press(1 << seq[i]);
            if (seq.size() == MAX_LEN) begin
               push_ev(EV_WIN, 0, MAX_LEN);
               target = ends_seen + 1;
               press(1 << seq[seq.size() - 1]);
               wait_end(target);
               done = 1;
            end else begin
               press(1 << seq[seq.size() - 1]);
            end
         end
      end
   endtask

   task automatic chk_idle(string name);
      chk({name, "_led"}, int'(bus.led), 0);
      chk({name, "_level"}, int'(bus.level), 0);
      chk({name, "_busy"}, int'(bus.busy), 0);
      chk({name, "_game_over"}, int'(bus.game_over), 0);
      chk({name, "_win"}, int'(bus.win), 0);
   endtask

   initial begin
      int target;
      bus.btn = 4'b0; bus.start = 1'b0; bus.rnd = 2'b0; bus.rnd_valid = 1'b0;
      rst = 1'b1;
      cyc(3);
      chk_idle("reset");
      rst = 1'b0;
      cyc(2);
      chk_idle("post_reset");

      // Directed: colour 2, then 0, then a two-hot wrong press, then a new game.
      start_game();
      extend_and_show(2);
      press(4'b0100);
      extend_and_show(0);
      chk("level_two", int'(bus.level), 2);
      push_ev(EV_LOSE, 0, 2);
      target = ends_seen + 1;
      press(4'b0100);
      press(4'b0011);
      wait_end(target);
      start_game();
      extend_and_show(1);
      chk("new_game_level", int'(bus.level), 1);
      chk("new_game_over", int'(bus.game_over), 0);

      // Idle player in WAIT_IN.
`ifdef SIMON_TIMEOUT_EN
      push_ev(EV_LOSE, 0, 1);
      target = ends_seen + 1;
      wait_end(target);
`else
      wait_ticks(100);
      chk("idle_busy", int'(bus.busy), 1);
      chk("idle_game_over", int'(bus.game_over), 0);
      chk("idle_led", int'(bus.led), 0);
      wrong_press(0);
`endif

      for (int g = 0; g < 25; g++) run_random_game(30);

      // Asynchronous abort in the middle of a playback.
      start_game();
      seq.push_back(3);
      bus.rnd = 2'd3;
      bus.rnd_valid = 1'b1;
      cyc(1);
      bus.rnd_valid = 1'b0;
      cyc(2);
      chk("pre_abort_busy", int'(bus.busy), 1);
      #2 rst = 1'b1;
      #1;
      chk_idle("async_abort");
      sb.delete();
      seq.delete();
      bus.btn = 4'b0001;
      cyc(2);
      rst = 1'b0;
      cyc(3);
      bus.btn = 4'b0;
      chk_idle("after_abort");
      run_random_game(0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
